// File: rtl/bus_seq_pkg.sv
// Shared encodings for the external bus cycle sequencer.
package bus_seq_pkg;

  // Bus phase / FSM state; the encoding is visible on the bus_phase pins.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAlo  = 2'd1,
    StAhi  = 2'd2,
    StXfer = 2'd3
  } bus_state_e;

  // Flag bits carried on the data pins during the address phases.
  localparam int unsigned FlagWeBit    = 0;
  localparam int unsigned FlagFetchBit = 1;

  function automatic logic [7:0] flag_byte(input logic is_fetch, input logic we);
    logic [7:0] b;
    b               = 8'h00;
    b[FlagWeBit]    = we;
    b[FlagFetchBit] = is_fetch;
    return b;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Fetch/execute arbiter: execute wins by default, but a fetch that has watched
// STARVE_LIMIT consecutive execute grants is served next.
module bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk_cpu,
  input  logic rst_n,
  input  logic f_req,
  input  logic e_req,
  input  logic f_mask,
  input  logic e_mask,
  input  logic grant_strobe,
  output logic grant_valid,
  output logic grant_is_fetch
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             f_elig;
  logic             e_elig;
  logic             starved;

  // A requester being acked this cycle is still holding req; ignore it.
  always_comb begin
    f_elig         = f_req & ~f_mask;
    e_elig         = e_req & ~e_mask;
    starved        = (starve_cnt == Limit);
    grant_valid    = f_elig | e_elig;
    grant_is_fetch = f_elig & (~e_elig | starved);
  end

  // Count execute grants taken while fetch waits; saturates at the limit.
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_strobe && grant_valid) begin
      if (grant_is_fetch || !f_req) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Runs each external bus transaction as ALO -> AHI -> XFER over the
// multiplexed address pins, arbitrating between fetch and execute requesters.
module bus_cycle_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [7:0]  f_rdata,
  input  logic        e_req,
  input  logic [15:0] e_addr,
  input  logic        e_we,
  input  logic [7:0]  e_wdata,
  output logic        e_ack,
  output logic [7:0]  e_rdata,
  input  logic        rdy,
  input  logic [7:0]  data_in,
  output logic [7:0]  bus_out,
  output logic [7:0]  data_out,
  output logic [7:0]  data_oe,
  output logic        sync,
  output logic        rw,
  output logic [1:0]  bus_phase
);

  bus_state_e  state;
  logic [15:0] addr_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic        is_fetch_q;

  logic        grant_valid;
  logic        grant_is_fetch;
  logic [15:0] g_addr;
  logic        g_we;
  logic [7:0]  g_wdata;

  bus_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_arbiter (
    .clk_cpu       (clk_cpu),
    .rst_n         (rst_n),
    .f_req         (f_req),
    .e_req         (e_req),
    .f_mask        (f_ack),
    .e_mask        (e_ack),
    .grant_strobe  (state == StIdle),
    .grant_valid   (grant_valid),
    .grant_is_fetch(grant_is_fetch)
  );

  // Transaction fields of the winning requester; fetches never write.
  always_comb begin
    g_addr  = grant_is_fetch ? f_addr : e_addr;
    g_we    = ~grant_is_fetch & e_we;
    g_wdata = grant_is_fetch ? 8'h00 : e_wdata;
  end

  assign bus_phase = state;

  // FSM, transaction latches and registered pin values for the next phase.
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      state      <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      is_fetch_q <= 1'b0;
      f_ack      <= 1'b0;
      e_ack      <= 1'b0;
      f_rdata    <= '0;
      e_rdata    <= '0;
      bus_out    <= '0;
      data_out   <= '0;
      data_oe    <= '0;
      sync       <= 1'b0;
      rw         <= 1'b1;
    end else begin
      f_ack <= 1'b0;
      e_ack <= 1'b0;
      unique case (state)
        StIdle: begin
          if (grant_valid) begin
            state      <= StAlo;
            addr_q     <= g_addr;
            we_q       <= g_we;
            wdata_q    <= g_wdata;
            is_fetch_q <= grant_is_fetch;
            bus_out    <= g_addr[7:0];
            data_out   <= flag_byte(grant_is_fetch, g_we);
            data_oe    <= 8'hFF;
            sync       <= grant_is_fetch;
            rw         <= ~g_we;
          end
        end
        StAlo: begin
          state   <= StAhi;
          bus_out <= addr_q[15:8];
        end
        StAhi: begin
          state    <= StXfer;
          bus_out  <= addr_q[7:0];
          data_out <= we_q ? wdata_q : 8'h00;
          data_oe  <= {8{we_q}};
        end
        StXfer: begin
          if (rdy) begin
            state    <= StIdle;
            bus_out  <= '0;
            data_out <= '0;
            data_oe  <= '0;
            sync     <= 1'b0;
            rw       <= 1'b1;
            if (is_fetch_q) begin
              f_ack <= 1'b1;
              if (!we_q) f_rdata <= data_in;
            end else begin
              e_ack <= 1'b1;
              if (!we_q) e_rdata <= data_in;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench: stimulus pushes expected transactions, a monitor pops one
// whenever the DUT enters ALO and checks every phase through the ack cycle.
module tb_bus_cycle_sequencer;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic        f_req, f_req_drv, gate_f;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [7:0]  f_rdata;
  logic        e_req;
  logic [15:0] e_addr;
  logic        e_we;
  logic [7:0]  e_wdata;
  logic        e_ack;
  logic [7:0]  e_rdata;
  logic        rdy;
  logic [7:0]  data_in;
  logic [7:0]  bus_out, data_out, data_oe;
  logic        sync, rw;
  logic [1:0]  bus_phase;

  // With gate_f set, fetch withdraws during execute ack cycles so execute can
  // win repeatedly and drive the starvation counter to its limit.
  assign f_req = f_req_drv & ~(gate_f & e_ack);

  bus_cycle_sequencer #(
    .STARVE_LIMIT(4),
    .CNT_W       (4)
  ) dut (
    .clk_cpu  (clk_cpu),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_ack    (f_ack),
    .f_rdata  (f_rdata),
    .e_req    (e_req),
    .e_addr   (e_addr),
    .e_we     (e_we),
    .e_wdata  (e_wdata),
    .e_ack    (e_ack),
    .e_rdata  (e_rdata),
    .rdy      (rdy),
    .data_in  (data_in),
    .bus_out  (bus_out),
    .data_out (data_out),
    .data_oe  (data_oe),
    .sync     (sync),
    .rw       (rw),
    .bus_phase(bus_phase)
  );

  always #5 clk_cpu = ~clk_cpu;

  int cyc = 0;
  always @(posedge clk_cpu) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    bit          fetch;
    bit          we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          waits;
    int          start;
    bit          abort;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cfg_waits = 0;
  logic [7:0] cfg_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] addr, input bit fetch, input bit we,
                          input logic [7:0] wdata, input logic [7:0] rdata,
                          input int waits, input int start, input bit abort);
    exp_t t;
    t.addr = addr; t.fetch = fetch; t.we = we; t.wdata = wdata; t.rdata = rdata;
    t.waits = waits; t.start = start; t.abort = abort;
    exp_q.push_back(t);
  endtask

  // One requester transaction: raise req, wait for ack, drop req.
  task automatic req_txn(input bit fetch, input logic [15:0] addr, input bit we,
                         input logic [7:0] wdata);
    int k;
    if (fetch) begin
      f_addr = addr; f_req_drv = 1'b1;
    end else begin
      e_addr = addr; e_we = we; e_wdata = wdata; e_req = 1'b1;
    end
    k = 0;
    do begin
      @(negedge clk_cpu);
      k++;
    end while (!(fetch ? f_ack : e_ack) && k < 200);
    chk(fetch ? "f_ack_timeout" : "e_ack_timeout", k < 200, 1);
    if (fetch) f_req_drv = 1'b0;
    else e_req = 1'b0;
  endtask

  // External device: rdy low for cfg_waits XFER cycles, decoy data until ready.
  initial begin : driver
    int waits_left;
    waits_left = 0;
    rdy = 1'b0;
    data_in = 8'hEE;
    forever begin
      @(negedge clk_cpu);
      if (bus_phase === 2'd1) waits_left = cfg_waits;
      if (bus_phase === 2'd3) begin
        if (waits_left > 0) begin
          rdy = 1'b0; data_in = 8'hC3; waits_left--;
        end else begin
          rdy = 1'b1; data_in = cfg_data;
        end
      end else begin
        rdy = 1'b0; data_in = 8'hEE;
      end
    end
  end

  // Monitor: each ALO entry pops one expected transaction and follows it.
  initial begin : monitor
    exp_t       t;
    int         n;
    logic [7:0] m_f_rdata, m_e_rdata;
    m_f_rdata = 8'h00;
    m_e_rdata = 8'h00;
    forever begin
      @(negedge clk_cpu);
      if (rst_n === 1'b1 && bus_phase === 2'd1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_txn: bus_out %0h with no expected transaction", bus_out);
        end else begin
          t = exp_q.pop_front();
          if (t.start >= 0) chk("alo_cycle", cyc, t.start);
          chk("alo_bus_out", bus_out, t.addr[7:0]);
          chk("alo_flags", data_out, {6'b0, t.fetch, t.we});
          chk("alo_oe", data_oe, 8'hFF);
          chk("alo_sync", sync, t.fetch);
          chk("alo_rw", rw, !t.we);
          chk("alo_acks", {f_ack, e_ack}, 2'b00);
          @(negedge clk_cpu);
          chk("ahi_phase", bus_phase, 2);
          chk("ahi_bus_out", bus_out, t.addr[15:8]);
          chk("ahi_flags", data_out, {6'b0, t.fetch, t.we});
          chk("ahi_oe", data_oe, 8'hFF);
          chk("ahi_sync", sync, t.fetch);
          chk("ahi_rw", rw, !t.we);
          @(negedge clk_cpu);
          if (t.abort) begin
            chk("abort_phase", bus_phase, 0);
            chk("abort_oe", data_oe, 8'h00);
            chk("abort_data_out", data_out, 8'h00);
            chk("abort_rw", rw, 1);
            chk("abort_acks", {f_ack, e_ack}, 2'b00);
            m_f_rdata = 8'h00;
            m_e_rdata = 8'h00;
            chk("abort_f_rdata", f_rdata, m_f_rdata);
            chk("abort_e_rdata", e_rdata, m_e_rdata);
          end else begin
            n = 0;
            while (bus_phase === 2'd3 && n < 64) begin
              chk("xfer_bus_out", bus_out, t.addr[7:0]);
              chk("xfer_data_out", data_out, t.we ? t.wdata : 8'h00);
              chk("xfer_oe", data_oe, t.we ? 8'hFF : 8'h00);
              chk("xfer_rw", rw, !t.we);
              chk("xfer_sync", sync, t.fetch);
              n++;
              @(negedge clk_cpu);
            end
            chk("xfer_len", n, t.waits + 1);
            if (t.start >= 0) chk("ack_cycle", cyc, t.start + 3 + t.waits);
            chk("ack_phase", bus_phase, 0);
            chk("ack_idle_oe", data_oe, 8'h00);
            chk("ack_idle_rw", rw, 1);
            chk("acks", {f_ack, e_ack}, t.fetch ? 2'b10 : 2'b01);
            if (!t.we) begin
              if (t.fetch) m_f_rdata = t.rdata;
              else m_e_rdata = t.rdata;
            end
            chk("f_rdata", f_rdata, m_f_rdata);
            chk("e_rdata", e_rdata, m_e_rdata);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal(1, "simulation did not complete");
  end

  initial begin : stimulus
    int s, k, nf;
    int e_offs[8];
    int f_offs[2];
    e_offs = '{1, 6, 11, 16, 25, 30, 35, 40};
    f_offs = '{21, 45};
    rst_n = 1'b0; f_req_drv = 1'b0; gate_f = 1'b0; e_req = 1'b0; e_we = 1'b0;
    e_wdata = 8'h00; f_addr = 16'h0000; e_addr = 16'h0000;

    // Reset held two cycles with both requesters pending; execute wins first,
    // fetch is granted in the execute ack cycle.
    cfg_data = 8'h11;
    push_exp(16'h0010, 1'b0, 1'b0, 8'h00, 8'h11, 0, 3, 1'b0);
    push_exp(16'hF00D, 1'b1, 1'b0, 8'h00, 8'h11, 0, 7, 1'b0);
    fork
      req_txn(1'b0, 16'h0010, 1'b0, 8'h00);
      req_txn(1'b1, 16'hF00D, 1'b0, 8'h00);
      begin
        repeat (2) begin
          @(negedge clk_cpu);
          chk("rst_phase", bus_phase, 0);
          chk("rst_bus_out", bus_out, 8'h00);
          chk("rst_data_out", data_out, 8'h00);
          chk("rst_oe", data_oe, 8'h00);
          chk("rst_rw", rw, 1);
          chk("rst_sync", sync, 0);
          chk("rst_acks", {f_ack, e_ack}, 2'b00);
          chk("rst_rdata", {f_rdata, e_rdata}, 16'h0000);
        end
        rst_n = 1'b1;
      end
    join

    // Fetch read.
    @(negedge clk_cpu);
    cfg_data = 8'hA9;
    push_exp(16'h1234, 1'b1, 1'b0, 8'h00, 8'hA9, 0, cyc + 1, 1'b0);
    req_txn(1'b1, 16'h1234, 1'b0, 8'h00);

    // Execute write; e_rdata must keep its previous value.
    @(negedge clk_cpu);
    cfg_data = 8'hD7;
    push_exp(16'h0200, 1'b0, 1'b1, 8'h55, 8'h00, 0, cyc + 1, 1'b0);
    req_txn(1'b0, 16'h0200, 1'b1, 8'h55);

    // Execute read stretched by three wait states.
    @(negedge clk_cpu);
    cfg_data = 8'h3C;
    cfg_waits = 3;
    push_exp(16'hBEEF, 1'b0, 1'b0, 8'h00, 8'h3C, 3, cyc + 1, 1'b0);
    req_txn(1'b0, 16'hBEEF, 1'b0, 8'h00);
    cfg_waits = 0;

    // Starvation guard: four execute writes, then fetch, twice over.
    @(negedge clk_cpu);
    s = cyc;
    cfg_data = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) push_exp(16'h8000, 1'b1, 1'b0, 8'h00, 8'h5A, 0, s + f_offs[0], 1'b0);
      else if (i == 9) push_exp(16'h8000, 1'b1, 1'b0, 8'h00, 8'h5A, 0, s + f_offs[1], 1'b0);
      else push_exp(16'h01FD, 1'b0, 1'b1, 8'h77, 8'h00, 0, s + e_offs[i < 4 ? i : i - 1], 1'b0);
    end
    gate_f = 1'b1;
    f_addr = 16'h8000; e_addr = 16'h01FD; e_we = 1'b1; e_wdata = 8'h77;
    e_req = 1'b1; f_req_drv = 1'b1;
    nf = 0; k = 0;
    while (nf < 2 && k < 200) begin
      @(negedge clk_cpu);
      k++;
      if (f_ack) nf++;
    end
    chk("starve_timeout", k < 200, 1);
    e_req = 1'b0; f_req_drv = 1'b0; gate_f = 1'b0;

    // Reset during AHI of an execute write, then the held request reissues.
    @(negedge clk_cpu);
    push_exp(16'h0456, 1'b0, 1'b1, 8'hA5, 8'h00, 0, cyc + 1, 1'b1);
    e_addr = 16'h0456; e_we = 1'b1; e_wdata = 8'hA5; e_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk_cpu);
      k++;
    end while (bus_phase !== 2'd2 && k < 20);
    chk("ahi_wait_timeout", k < 20, 1);
    rst_n = 1'b0;
    @(negedge clk_cpu);
    push_exp(16'h0456, 1'b0, 1'b1, 8'hA5, 8'h00, 0, cyc + 1, 1'b0);
    rst_n = 1'b1;
    req_txn(1'b0, 16'h0456, 1'b1, 8'hA5);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk_cpu);
      k++;
    end
    repeat (3) @(negedge clk_cpu);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
Sequences every external bus transaction of the 6502 core over the multiplexed 8-bit address pins and 8-bit bidirectional data pins. It arbitrates between the instruction-fetch requester and the execute (operand/stack) requester, then runs address-low, address-high and data phases. It honours RDY wait states and returns read data with a one-cycle ack. It replaces ad-hoc pc/ab/data_bus_buffer driving in the top level; the top level maps bus_out to uo_out and data_out/data_oe to uio_out/uio_oe.

Parameters:
STARVE_LIMIT, 4, max consecutive execute grants while a fetch request is pending (range 1..15)
CNT_W, 4, width of starvation counter

Ports:
clk_cpu  in  1  CPU clock; all state changes on rising edge
rst_n  in  1  synchronous, active-low reset
f_req  in  1  fetch request; held high until f_ack
f_addr  in  16  fetch address; stable while f_req high
f_ack  out  1  one-cycle pulse; fetch transfer complete, f_rdata valid
f_rdata  out  8  fetched byte; held until next fetch ack
e_req  in  1  execute request; held high until e_ack
e_addr  in  16  execute address
e_we  in  1  1 = write, 0 = read
e_wdata  in  8  write data
e_ack  out  1  one-cycle pulse; execute transfer complete
e_rdata  out  8  read byte; held until next execute read ack
rdy  in  1  external ready; low stretches the data phase
data_in  in  8  data pins, input path
bus_out  out  8  multiplexed address pins
data_out  out  8  data pins, output path
data_oe  out  8  data pin enables (1 = drive)
sync  out  1  high for the whole transaction when the grant is fetch
rw  out  1  1 = read, 0 = write (6502 polarity); 1 when idle
bus_phase  out  2  0 = IDLE, 1 = ALO, 2 = AHI, 3 = XFER

Behaviour:
- Reset (rst_n low at an edge): state IDLE; starvation counter 0; latched addr/we/wdata 0; f_ack=e_ack=0; f_rdata=e_rdata=0. Outputs in IDLE: bus_out=0, data_out=0, data_oe=0, sync=0, rw=1, bus_phase=0. A transaction in flight is abandoned with no ack; write data is never presented.
- FSM IDLE->ALO->AHI->XFER->IDLE. Outputs are Moore outputs from the state and latched transaction registers.
- IDLE: evaluate eligible requests. A requester whose ack is high this cycle is masked. On a grant, latch addr/we/wdata/is_fetch and go to ALO. Fetch writes are impossible (we forced 0).
- ALO: bus_out=addr[7:0]; data_out={6'b0,is_fetch,we}; data_oe=8'hFF.
- AHI: bus_out=addr[15:8]; data_out and data_oe as in ALO.
- XFER: bus_out=addr[7:0].
  - Write: data_out=wdata, data_oe=8'hFF, rw=0.
  - Read: data_oe=0, data_out=0, rw=1.
  - rdy=0: remain in XFER (unbounded).
  - rdy=1: complete. On reads, capture data_in into the requester's rdata at this edge. Go to IDLE.
- Ack: registered; high in the IDLE cycle immediately after XFER completes, for exactly one cycle.
- sync and rw hold their values across ALO/AHI/XFER of the transaction.
- Requester protocol: drop req in the cycle after ack. req high in that cycle is a new request. Changing addr while req is high and not yet acked is illegal (the latched copy is used).
- Latency (rdy=1): req seen in IDLE at cycle N -> ALO N+1, AHI N+2, XFER N+3, ack N+4.
- Throughput: back-to-back alternating requesters take 4 cycles each, because the other requester can be granted in the ack cycle. The same requester repeating takes 5 cycles.
- Arbitration: execute has priority over fetch, with a starvation guard.
  - Counter counts execute grants made while f_req is high.
  - Counter clears on any fetch grant, or on an execute grant with f_req low.
  - When count == STARVE_LIMIT and fetch is eligible, fetch wins.
  - Counter saturates at STARVE_LIMIT and never wraps.

Decomposition:
- Package bus_seq_pkg: state/bus_phase encodings (IDLE=0, ALO=1, AHI=2, XFER=3) and the flag-bit positions in data_out (bit0 = we, bit1 = is_fetch).
- Sub-module bus_arbiter: inputs f_req, e_req, ack masks and a grant-strobe; outputs grant_valid, grant_is_fetch; contains the starvation counter.
- FSM, latches and pin muxing stay in bus_cycle_sequencer.

Test Plan:
- Reset with both reqs high: rst_n=0 for 2 cycles -> bus_phase=0, bus_out=00, data_oe=00, rw=1, sync=0, no acks; first grant is ALO one cycle after release.
- Fetch read of 16'h1234, data_in=8'hA9 in XFER, rdy=1 -> bus_out 34,12,34 with data_out=02 during ALO/AHI; sync=1; f_ack at N+4; f_rdata=A9.
- Execute write of 16'h0200, e_wdata=8'h55 -> ALO/AHI data_out=01; XFER data_out=55, data_oe=FF, rw=0; e_ack at N+4; e_rdata unchanged.
- Execute read with rdy low for 3 XFER cycles, data_in=8'h3C on the rdy-high cycle -> XFER lasts 4 cycles; e_ack at N+7; e_rdata=3C.
- f_req and e_req held continuously, STARVE_LIMIT=4 -> grant order E,E,E,E,F,E,E,E,E,F; 4-cycle spacing between alternating grants.
- rst_n low during AHI of an execute write -> next cycle IDLE, data_oe=00, no e_ack; after release with e_req still high, a fresh ALO for the same address.
